// File: rtl/addr_unmap.sv
// Reverse side of the hashed address mapping: records (bucket, sva) pairs in per-bucket
// slot tables, hands out slot tags, and recovers the sva from (bucket, tag) responses.
module addr_unmap #(
   parameter int unsigned ADDR_WIDTH     = 64,
   parameter int unsigned LG_NUM_BUCKETS = 2,
   parameter int unsigned LG_SLOTS       = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rec_valid,
   output logic                            rec_ready,
   input  logic [LG_NUM_BUCKETS-1:0]       rec_bucket,
   input  logic [ADDR_WIDTH-1:0]           rec_addr,
   output logic                            tag_valid,
   input  logic                            tag_ready,
   output logic [LG_SLOTS-1:0]             tag_out,
   input  logic                            lkp_valid,
   output logic                            lkp_ready,
   input  logic [LG_NUM_BUCKETS-1:0]       lkp_bucket,
   input  logic [LG_SLOTS-1:0]             lkp_tag,
   input  logic                            lkp_release,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_hit,
   output logic [ADDR_WIDTH-1:0]           out_addr,
   output logic [(2**LG_NUM_BUCKETS)-1:0]  bucket_full
);

   localparam int unsigned NUM_BUCKETS = 2 ** LG_NUM_BUCKETS;
   localparam int unsigned NUM_SLOTS   = 2 ** LG_SLOTS;
   localparam int unsigned NUM_ENTRIES = NUM_BUCKETS * NUM_SLOTS;
   localparam int unsigned IDX_W       = LG_NUM_BUCKETS + LG_SLOTS;

   logic [NUM_BUCKETS-1:0][NUM_SLOTS-1:0] slot_valid;
   logic [NUM_BUCKETS-1:0][NUM_SLOTS-1:0] slot_valid_next;
   logic [NUM_BUCKETS-1:0]                full_next;
   logic [ADDR_WIDTH-1:0]                 addr_mem [NUM_ENTRIES];

   logic                rec_accept;
   logic                lkp_accept;
   logic                lkp_hit;
   logic [LG_SLOTS-1:0] alloc_slot;
   logic [IDX_W-1:0]    rec_idx;
   logic [IDX_W-1:0]    lkp_idx;

   assign rec_ready  = !bucket_full[rec_bucket] && (!tag_valid || tag_ready);
   assign lkp_ready  = !out_valid || out_ready;
   assign rec_accept = rec_valid && rec_ready;
   assign lkp_accept = lkp_valid && lkp_ready;
   assign lkp_hit    = slot_valid[lkp_bucket][lkp_tag];
   assign rec_idx    = {rec_bucket, alloc_slot};
   assign lkp_idx    = {lkp_bucket, lkp_tag};

   // Lowest-index free slot in the target bucket, from pre-release valid bits
   always_comb begin
      alloc_slot = '0;
      for (int s = int'(NUM_SLOTS) - 1; s >= 0; s--) begin
         if (!slot_valid[rec_bucket][s]) alloc_slot = LG_SLOTS'(s);
      end
   end

   // Next valid bits; full flags derive from them so they track the table exactly
   always_comb begin
      slot_valid_next = slot_valid;
      if (rec_accept) slot_valid_next[rec_bucket][alloc_slot] = 1'b1;
      if (lkp_accept && lkp_hit && lkp_release) slot_valid_next[lkp_bucket][lkp_tag] = 1'b0;
      full_next = '0;
      for (int b = 0; b < int'(NUM_BUCKETS); b++) begin
         full_next[b] = &slot_valid_next[b];
      end
   end

   always_ff @(posedge clk) begin
      if (rec_accept) addr_mem[rec_idx] <= rec_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_valid  <= '0;
         bucket_full <= '0;
         tag_valid   <= 1'b0;
         tag_out     <= '0;
         out_valid   <= 1'b0;
         out_hit     <= 1'b0;
         out_addr    <= '0;
      end else begin
         slot_valid  <= slot_valid_next;
         bucket_full <= full_next;
         if (rec_accept) begin
            tag_valid <= 1'b1;
            tag_out   <= alloc_slot;
         end else if (tag_ready) begin
            tag_valid <= 1'b0;
         end
         if (lkp_accept) begin
            out_valid <= 1'b1;
            out_hit   <= lkp_hit;
            out_addr  <= lkp_hit ? addr_mem[lkp_idx] : '0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
